// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the UART memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int CNT_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Packs accepted bytes little-endian into a 32-bit word and
//               flags the cycle in which the fourth byte arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic              clear_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [CNT_W-1:0]  byte_cnt_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;

  // word_o is the assembly register with this cycle's byte merged in, so a
  // completing or flushed word is available in the cycle the byte arrives.
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    assign word_o[k*BYTE_W +: BYTE_W] =
      (accept_i && (cnt_q == CNT_W'(k))) ? byte_i : asm_q[k*BYTE_W +: BYTE_W];
  end

  assign word_done_o = accept_i && (cnt_q == LAST_LANE);
  assign byte_cnt_o  = cnt_q;

  // Next-state: clearing the register on completion keeps unfilled lanes zero,
  // which provides the zero padding for a flushed partial word.
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i || word_done_o) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + CNT_ONE;
      asm_d = word_o;
    end
  end

  // Lane counter and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule : byte_packer
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_loader
// Description : Drains a receive FIFO, packs bytes into little-endian words
//               and writes them to CPU memory at sequential word addresses.
//               Optional macro LOADER_CHECKSUM_EN adds a modulo-256 checksum
//               of all bytes accepted while loading.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int                 ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              SYS_reset,
  input  logic              load_enable,
  input  logic              load_finish,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              byte_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [BYTE_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              finish;
  logic              write_req;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] word;
  logic              word_done;

  // FIFO bytes are taken whenever they show up in LOAD, even with byte_req low.
  assign accept = (state_q == LOAD) && byte_valid;
  assign finish = (state_q == LOAD) && load_finish;

  // A coincident 4th byte makes the full word the flush write; otherwise any
  // partial word (including a byte arriving with finish) is written padded.
  assign write_req = word_done || (finish && (accept || (byte_cnt != '0)));

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (SYS_reset),
    .accept_i    (accept),
    .clear_i     (finish),
    .byte_i      (byte_in),
    .byte_cnt_o  (byte_cnt),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // Next-state and write datapath; the write strobe lands one cycle after the
  // completing byte, which for a finish is the single FLUSH cycle.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      LOAD:    if (load_finish) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase

    if (write_req) begin
      if (count_q == FULL_CNT) begin
        ovf_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = BASE_ADDR + idx_q;
        wdata_d = word;
        idx_d   = idx_q + IDX_ONE;
        count_d = count_q + CNT_ONE;
      end
    end
  end

  // State and write-port registers.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q <= LOAD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Request is held low while reset is asserted so every output reads zero.
  assign byte_req   = SYS_reset && (state_q == LOAD) && load_enable;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign load_done  = (state_q == DONE);
  assign overflow   = ovf_q;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  assign csum_d = accept ? (csum_q + byte_in) : csum_q;

  // Running sum of accepted bytes; stops once LOAD is left.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) csum_q <= '0;
    else            csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  // Checksum disabled: no port, no logic.
`endif

endmodule : uart_mem_loader
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_loader
// Description : Self-checking bench for uart_mem_loader. Two instances (a
//               4-word memory at base 0 and a 16-word memory at base 13)
//               share one stimulus stream and are compared each cycle
//               against a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

  logic       clk = 1'b0;
  logic       SYS_reset = 1'b1;
  logic       load_enable = 1'b0;
  logic       load_finish = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;

  logic        req_a, we_a, done_a, ovf_a;
  logic [1:0]  addr_a;
  logic [31:0] data_a;
  logic [2:0]  cnt_a;
  logic        req_b, we_b, done_b, ovf_b;
  logic [3:0]  addr_b;
  logic [31:0] data_b;
  logic [4:0]  cnt_b;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_a, csum_b;
`endif

  always #5 clk = ~clk;

  uart_mem_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_dut_a (
    .clk(clk), .SYS_reset(SYS_reset), .load_enable(load_enable),
    .load_finish(load_finish), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(data_a),
    .word_count(cnt_a), .load_done(done_a), .overflow(ovf_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(csum_a)
`endif
  );

  uart_mem_loader #(.ADDR_W(4), .BASE_ADDR(4'd13)) u_dut_b (
    .clk(clk), .SYS_reset(SYS_reset), .load_enable(load_enable),
    .load_finish(load_finish), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(data_b),
    .word_count(cnt_b), .load_done(done_b), .overflow(ovf_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(csum_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the word in progress, load phase
  // (0 loading, 1 flushing, 2 done), and per-instance write bookkeeping.
  logic [7:0]  m_bytes[$];
  int          m_phase;
  int unsigned m_sum;
  int          m_cap[2]  = '{4, 16};
  int          m_base[2] = '{0, 13};
  int          m_count[2];
  bit          m_ovf[2];
  bit          m_we[2];
  int          m_addr[2];
  logic [31:0] m_data[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_phase = 0;
    m_sum   = 0;
    for (int d = 0; d < 2; d++) begin
      m_count[d] = 0; m_ovf[d] = 0; m_we[d] = 0; m_addr[d] = 0; m_data[d] = 0;
    end
  endtask

  // A completed or flushed word goes to base+count (mod capacity) unless full.
  task automatic model_emit();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < m_bytes.size(); i++) w = w | (32'(m_bytes[i]) << (8 * i));
    m_bytes.delete();
    for (int d = 0; d < 2; d++) begin
      if (m_count[d] == m_cap[d]) m_ovf[d] = 1;
      else begin
        m_we[d]   = 1;
        m_addr[d] = (m_base[d] + m_count[d]) % m_cap[d];
        m_data[d] = w;
        m_count[d]++;
      end
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit f);
    m_we[0] = 0; m_we[1] = 0;
    if (m_phase == 0) begin
      if (v) begin
        m_bytes.push_back(b);
        m_sum = m_sum + b;
      end
      if (m_bytes.size() == 4) model_emit();
      if (f) begin
        if (m_bytes.size() > 0) model_emit();
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end
  endtask

  task automatic compare_all();
    check_eq("a_we",    we_a,   m_we[0]);
    check_eq("a_addr",  addr_a, m_addr[0]);
    check_eq("a_data",  data_a, m_data[0]);
    check_eq("a_count", cnt_a,  m_count[0]);
    check_eq("a_ovf",   ovf_a,  m_ovf[0]);
    check_eq("a_done",  done_a, m_phase == 2);
    check_eq("b_we",    we_b,   m_we[1]);
    check_eq("b_addr",  addr_b, m_addr[1]);
    check_eq("b_data",  data_b, m_data[1]);
    check_eq("b_count", cnt_b,  m_count[1]);
    check_eq("b_ovf",   ovf_b,  m_ovf[1]);
    check_eq("b_done",  done_b, m_phase == 2);
`ifdef LOADER_CHECKSUM_EN
    check_eq("a_csum", csum_a, m_sum & 32'hFF);
    check_eq("b_csum", csum_b, m_sum & 32'hFF);
`endif
  endtask

  // One clock: drive inputs, check the request, advance model, check outputs.
  task automatic cycle(input bit v, input logic [7:0] b, input bit f, input bit e);
    byte_valid = v; byte_in = b; load_finish = f; load_enable = e;
    #1;
    check_eq("a_byte_req", req_a, (m_phase == 0) && e);
    check_eq("b_byte_req", req_b, (m_phase == 0) && e);
    model_step(v, b, f);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    SYS_reset = 1'b0; byte_valid = 1'b0; load_finish = 1'b0;
    load_enable = 1'b1; byte_in = 8'h00;
    #1;
    check_eq("rst_we",    we_a | we_b, 0);
    check_eq("rst_addr",  {addr_b, addr_a}, 0);
    check_eq("rst_data",  data_a | data_b, 0);
    check_eq("rst_count", {cnt_b, cnt_a}, 0);
    check_eq("rst_ovf",   ovf_a | ovf_b, 0);
    check_eq("rst_done",  done_a | done_b, 0);
    check_eq("rst_req",   req_a | req_b, 0);
`ifdef LOADER_CHECKSUM_EN
    check_eq("rst_csum",  {csum_b, csum_a}, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    SYS_reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] seq1[8];
    model_reset();
    #2;

    // Two full words.
    do_reset();
    seq1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) begin
      cycle(1, seq1[i], 0, 1);
      if (i == 3) begin
        check_eq("tp1_w0_we", we_a, 1);
        check_eq("tp1_w0_addr", addr_a, 0);
        check_eq("tp1_w0_data", data_a, 32'h00000013);
      end
    end
    check_eq("tp1_w1_addr", addr_a, 1);
    check_eq("tp1_w1_data", data_a, 32'h00100093);
    check_eq("tp1_count", cnt_a, 2);
    check_eq("tp1_b_addr", addr_b, 14);

    // Partial word flushed with zero padding.
    do_reset();
    cycle(1, 8'hAA, 0, 1);
    cycle(1, 8'hBB, 0, 1);
    cycle(1, 8'hCC, 0, 1);
    cycle(0, 8'h00, 1, 1);
    check_eq("tp2_flush_we", we_a, 1);
    check_eq("tp2_flush_data", data_a, 32'h00CCBBAA);
    check_eq("tp2_flush_addr", addr_a, 0);
    check_eq("tp2_not_done_yet", done_a, 0);
    cycle(1, 8'h55, 0, 1);
    check_eq("tp2_done", done_a, 1);
    check_eq("tp2_req", req_a, 0);
    check_eq("tp2_count", cnt_a, 1);
    cycle(1, 8'h66, 1, 1);

    // Fourth byte coincident with finish: single full write.
    do_reset();
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    cycle(1, 8'h33, 0, 1);
    cycle(1, 8'h44, 1, 1);
    check_eq("tp3_we", we_a, 1);
    check_eq("tp3_data", data_a, 32'h44332211);
    cycle(0, 8'h00, 0, 1);
    check_eq("tp3_no_pad", we_a, 0);
    check_eq("tp3_count", cnt_a, 1);

    // Overflow on the 4-word instance; the 16-word one wraps its address.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 8'(i + 1), 0, 1);
    check_eq("tp4_count", cnt_a, 4);
    check_eq("tp4_ovf", ovf_a, 1);
    check_eq("tp4_req", req_a, 1);
    check_eq("tp4_b_count", cnt_b, 5);
    check_eq("tp4_b_addr", addr_b, 1);

    // Pause via load_enable.
    do_reset();
    cycle(1, 8'h5A, 0, 1);
    cycle(1, 8'h6B, 0, 1);
    repeat (5) cycle(0, 8'h00, 0, 0);
    check_eq("tp5_req_gap", req_a, 0);
    cycle(1, 8'h7C, 0, 1);
    cycle(1, 8'h8D, 0, 1);
    check_eq("tp5_we", we_a, 1);
    check_eq("tp5_data", data_a, 32'h8D7C6B5A);

    // Reset mid-word discards the partial word.
    do_reset();
    cycle(1, 8'hFF, 0, 1);
    cycle(1, 8'h02, 0, 1);
`ifdef LOADER_CHECKSUM_EN
    check_eq("tp6_csum", csum_a, 8'h01);
`endif
    do_reset();
    cycle(1, 8'h01, 0, 1);
    cycle(1, 8'h02, 0, 1);
    cycle(1, 8'h03, 0, 1);
    cycle(1, 8'h04, 0, 1);
    check_eq("tp6_we", we_a, 1);
    check_eq("tp6_addr", addr_a, 0);
    check_eq("tp6_data", data_a, 32'h04030201);

    // Randomized loads with random finish points and stray inputs afterwards.
    for (int r = 0; r < 40; r++) begin
      int len;
      int tail;
      do_reset();
      len  = $urandom_range(0, 30);
      tail = $urandom_range(0, 6);
      for (int c = 0; c < len; c++)
        cycle($urandom_range(0, 9) < 7, 8'($urandom), 0, $urandom_range(0, 9) < 8);
      if ($urandom_range(0, 4) != 0)
        cycle($urandom_range(0, 1) == 1, 8'($urandom), 1, 1);
      for (int c = 0; c < tail; c++)
        cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_mem_loader
`default_nettype wire
